// File: rtl/pipeline_stage_chain.sv
// ============================================================================
// Module   : pipeline_stage_chain
// Brief    : Multi-stage pipeline register chain with valid bits, stall,
//            per-stage flush and registered occupancy count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_stage_chain #(
    parameter int              N         = 32,
    parameter int              STAGES    = 1,
    parameter logic [N-1:0]    NOP_VALUE = {N{1'b0}},
    parameter bit              NEGEDGE   = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        stall_i,
    input  logic [STAGES-1:0]           flush_i,
    input  logic [N-1:0]                data_i,
    input  logic                        valid_i,
    output logic [N-1:0]                data_o,
    output logic                        valid_o,
    output logic [STAGES-1:0]           stage_valid_o,
    output logic [$clog2(STAGES+1)-1:0] occupancy_o
);

    localparam int c_OCC_W = $clog2(STAGES+1);

    logic                 w_clk;
    logic                 w_advance;
    logic [N-1:0]         w_data_nxt  [STAGES];
    logic [STAGES-1:0]    w_valid_nxt;
    logic [c_OCC_W-1:0]   w_occ_nxt;

    logic [N-1:0]         r_data      [STAGES];
    logic [STAGES-1:0]    r_valid;
    logic [c_OCC_W-1:0]   r_occ;

    // Edge selection is static, so this reduces to a wire or a single inverter.
    assign w_clk     = NEGEDGE ? ~clk : clk;
    assign w_advance = enable & ~stall_i;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_data_nxt[k]  = r_data[k];
            w_valid_nxt[k] = r_valid[k];
        end

        if (flush_i[0]) begin
            w_data_nxt[0]  = NOP_VALUE;
            w_valid_nxt[0] = 1'b0;
        end else if (w_advance) begin
            // Invalid input is replaced by the NOP so X on data_i never propagates.
            w_data_nxt[0]  = valid_i ? data_i : NOP_VALUE;
            w_valid_nxt[0] = valid_i;
        end

        for (int k = 1; k < STAGES; k++) begin
            if (flush_i[k]) begin
                w_data_nxt[k]  = NOP_VALUE;
                w_valid_nxt[k] = 1'b0;
            end else if (w_advance) begin
                w_data_nxt[k]  = r_data[k-1];
                w_valid_nxt[k] = r_valid[k-1];
            end
        end
    end

    always_comb begin
        w_occ_nxt = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_occ_nxt = w_occ_nxt + c_OCC_W'(w_valid_nxt[k]);
        end
    end

    always_ff @(posedge w_clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= NOP_VALUE;
            end
            r_valid <= '0;
            r_occ   <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= w_data_nxt[k];
            end
            r_valid <= w_valid_nxt;
            r_occ   <= w_occ_nxt;
        end
    end

    assign data_o        = r_data[STAGES-1];
    assign valid_o       = r_valid[STAGES-1];
    assign stage_valid_o = r_valid;
    assign occupancy_o   = r_occ;

endmodule

`default_nettype wire
